// File: rtl/clock_div_pkg.sv
// Shared constants and types for the programmable clock divider bank.
// The step-mode path is built only when CLOCK_DIV_STEP_EN is defined.
package clock_div_pkg;

   localparam int COUNT_WIDTH_DEFAULT = 24;

   // 27 MHz / (2 * 13_500_000) gives a 1 Hz square wave
   localparam int DEFAULT_DIVISOR     = 13_499_999;

   // A divisor of zero gives clock_in/2 output, for simulation and test
   localparam int FAST_DIVISOR        = 0;

   typedef enum logic [1:0] {
      CH_HOLD,
      CH_RUN,
      CH_STEP,
      CH_LOAD
   } ch_mode_e;

   function automatic int sel_width(input int channels);
      return (channels > 1) ? $clog2(channels) : 1;
   endfunction

endpackage

// File: rtl/clock_div_channel.sv
// One divider channel: divisor and counter registers, square-wave toggle and tick strobe.
// Operating priority is load, then step mode, then enable, then hold.
module clock_div_channel
   import clock_div_pkg::*;
#(
   parameter int COUNT_WIDTH   = COUNT_WIDTH_DEFAULT,
   parameter int RESET_DIVISOR = DEFAULT_DIVISOR
) (
   input  logic                   clock_in,
   input  logic                   reset_n,
   input  logic                   enable,
   input  logic                   load,
   input  logic [COUNT_WIDTH-1:0] divisor_in,
   input  logic                   step_mode,
   input  logic                   step_pulse,
   output logic                   clock_out,
   output logic                   tick
);

   ch_mode_e               mode;
   logic [COUNT_WIDTH-1:0] div_reg, div_next;
   logic [COUNT_WIDTH-1:0] cnt_reg, cnt_next;
   logic                   clk_reg, clk_next;
   logic                   tick_reg, tick_next;

   always_comb begin
      if (load)
         mode = CH_LOAD;
      else if (step_mode)
         mode = CH_STEP;
      else if (enable)
         mode = CH_RUN;
      else
         mode = CH_HOLD;
   end

   always_comb begin
      div_next  = div_reg;
      cnt_next  = cnt_reg;
      clk_next  = clk_reg;
      tick_next = 1'b0;
      unique case (mode)
         CH_LOAD: begin
            div_next = divisor_in;
            cnt_next = '0;
         end
         CH_STEP: begin
            // Counter parks at zero so leaving step mode yields a full half-period
            cnt_next = '0;
            if (step_pulse) begin
               clk_next  = ~clk_reg;
               tick_next = 1'b1;
            end
         end
         CH_RUN: begin
            if (cnt_reg == div_reg) begin
               cnt_next  = '0;
               clk_next  = ~clk_reg;
               tick_next = 1'b1;
            end else begin
               cnt_next = cnt_reg + 1'b1;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clock_in or negedge reset_n) begin
      if (!reset_n) begin
         div_reg  <= COUNT_WIDTH'(RESET_DIVISOR);
         cnt_reg  <= '0;
         clk_reg  <= 1'b0;
         tick_reg <= 1'b0;
      end else begin
         div_reg  <= div_next;
         cnt_reg  <= cnt_next;
         clk_reg  <= clk_next;
         tick_reg <= tick_next;
      end
   end

   assign clock_out = clk_reg;
   assign tick      = tick_reg;

endmodule

// File: rtl/clock_divider_bank.sv
// Bank of independent programmable clock/tick channels with run-time divisor loads.
// Define CLOCK_DIV_STEP_EN to add the step_mode/step ports for hand-clocked bring-up.
module clock_divider_bank #(
   parameter int CHANNELS        = 2,
   parameter int COUNT_WIDTH     = clock_div_pkg::COUNT_WIDTH_DEFAULT,
   parameter int DEFAULT_DIVISOR = clock_div_pkg::DEFAULT_DIVISOR,
   parameter int SEL_WIDTH       = clock_div_pkg::sel_width(CHANNELS)
) (
   input  logic                   clock_in,
   input  logic                   reset_n,
   input  logic [CHANNELS-1:0]    enable,
   input  logic                   load,
   input  logic [SEL_WIDTH-1:0]   load_sel,
   input  logic [COUNT_WIDTH-1:0] divisor_in,
`ifdef CLOCK_DIV_STEP_EN
   input  logic [CHANNELS-1:0]    step_mode,
   input  logic                   step,
`endif
   output logic [CHANNELS-1:0]    clock_out,
   output logic [CHANNELS-1:0]    tick
);

   logic [CHANNELS-1:0] load_vec;
   logic [CHANNELS-1:0] step_mode_int;
   logic                step_pulse;

`ifdef CLOCK_DIV_STEP_EN
   logic step_prev_reg;
   logic step_edge_reg;

   // Edge is registered, so the toggle lands one edge after step is first seen high
   always_ff @(posedge clock_in or negedge reset_n) begin
      if (!reset_n) begin
         step_prev_reg <= 1'b0;
         step_edge_reg <= 1'b0;
      end else begin
         step_prev_reg <= step;
         step_edge_reg <= step & ~step_prev_reg;
      end
   end

   assign step_mode_int = step_mode;
   assign step_pulse    = step_edge_reg;
`else
   assign step_mode_int = '0;
   assign step_pulse    = 1'b0;
`endif

   generate
      for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_channel
         // A load_sel at or beyond CHANNELS matches no channel and is dropped
         assign load_vec[gi] = load && (load_sel == SEL_WIDTH'(gi));

         clock_div_channel #(
            .COUNT_WIDTH   (COUNT_WIDTH),
            .RESET_DIVISOR (DEFAULT_DIVISOR)
         ) u_channel (
            .clock_in   (clock_in),
            .reset_n    (reset_n),
            .enable     (enable[gi]),
            .load       (load_vec[gi]),
            .divisor_in (divisor_in),
            .step_mode  (step_mode_int[gi]),
            .step_pulse (step_pulse),
            .clock_out  (clock_out[gi]),
            .tick       (tick[gi])
         );
      end
   endgenerate

endmodule

// File: tb/tb_clock_divider_bank.sv
// Directed bench for clock_divider_bank with divisor 3 at reset and a 2-bit load_sel.
// The step scenario is included only when CLOCK_DIV_STEP_EN is defined.
module tb_clock_divider_bank;

   localparam int CH = 2;
   localparam int CW = 24;
   localparam int SW = 2;

   logic          clock_in   = 1'b0;
   logic          reset_n    = 1'b0;
   logic [CH-1:0] enable     = '0;
   logic          load       = 1'b0;
   logic [SW-1:0] load_sel   = '0;
   logic [CW-1:0] divisor_in = '0;
   logic [CH-1:0] step_mode  = '0;
   logic          step       = 1'b0;
   logic [CH-1:0] clock_out;
   logic [CH-1:0] tick;

   int tests_run    = 0;
   int tests_failed = 0;

   clock_divider_bank #(
      .CHANNELS        (CH),
      .COUNT_WIDTH     (CW),
      .DEFAULT_DIVISOR (3),
      .SEL_WIDTH       (SW)
   ) dut (
      .clock_in   (clock_in),
      .reset_n    (reset_n),
      .enable     (enable),
      .load       (load),
      .load_sel   (load_sel),
      .divisor_in (divisor_in),
`ifdef CLOCK_DIV_STEP_EN
      .step_mode  (step_mode),
      .step       (step),
`endif
      .clock_out  (clock_out),
      .tick       (tick)
   );

   always #5 clock_in = ~clock_in;

   // Leaves the bench at a falling edge just after reset release; next rising edge is edge 1
   task automatic do_reset(input logic [CH-1:0] en, input logic [CH-1:0] sm);
      @(negedge clock_in);
      reset_n   = 1'b0;
      enable    = en;
      step_mode = sm;
      load      = 1'b0;
      step      = 1'b0;
      @(negedge clock_in);
      @(negedge clock_in);
      reset_n = 1'b1;
   endtask

   task automatic test_reset;
      logic [CH-1:0] exp_tick, exp_clk;
      @(negedge clock_in);
      reset_n = 1'b0;
      enable  = '1;
      @(negedge clock_in);
      tests_run++;
      if (clock_out !== 2'b00) begin
         tests_failed++;
         $display("FAIL reset_clock_out: got %b want 00", clock_out);
      end
      tests_run++;
      if (tick !== 2'b00) begin
         tests_failed++;
         $display("FAIL reset_tick: got %b want 00", tick);
      end
      reset_n = 1'b1;
      for (int k = 1; k <= 12; k++) begin
         @(negedge clock_in);
         exp_tick = (k % 4 == 0) ? 2'b11 : 2'b00;
         exp_clk  = ((k / 4) % 2 == 1) ? 2'b11 : 2'b00;
         tests_run++;
         if (tick !== exp_tick || clock_out !== exp_clk) begin
            tests_failed++;
            $display("FAIL run_edge%0d: got tick=%b clk=%b want tick=%b clk=%b",
                     k, tick, clock_out, exp_tick, exp_clk);
         end
      end
      $display("[TB] test_reset: free-running divisor 3 done");
   endtask

   task automatic test_load;
      logic exp_t0, exp_t1, exp_c0, exp_c1;
      do_reset(2'b11, 2'b00);
      @(negedge clock_in);
      @(negedge clock_in);
      load       = 1'b1;
      load_sel   = 2'd1;
      divisor_in = 24'd1;
      @(negedge clock_in);
      load = 1'b0;
      tests_run++;
      if (tick !== 2'b00 || clock_out !== 2'b00) begin
         tests_failed++;
         $display("FAIL load_edge: got tick=%b clk=%b want tick=00 clk=00", tick, clock_out);
      end
      for (int j = 1; j <= 8; j++) begin
         @(negedge clock_in);
         exp_t1 = (j % 2 == 0);
         exp_c1 = ((j / 2) % 2 == 1);
         exp_t0 = (j == 1 || j == 5);
         exp_c0 = (j >= 1 && j < 5);
         tests_run++;
         if (tick !== {exp_t1, exp_t0} || clock_out !== {exp_c1, exp_c0}) begin
            tests_failed++;
            $display("FAIL load_after%0d: got tick=%b clk=%b want tick=%b clk=%b",
                     j, tick, clock_out, {exp_t1, exp_t0}, {exp_c1, exp_c0});
         end
      end
      $display("[TB] test_load: channel 1 divisor 1 done");
   endtask

   task automatic test_hold;
      logic exp_t1;
      do_reset(2'b11, 2'b00);
      @(negedge clock_in);
      @(negedge clock_in);
      enable = 2'b10;
      for (int k = 1; k <= 5; k++) begin
         @(negedge clock_in);
         exp_t1 = (k == 2);
         tests_run++;
         if (tick !== {exp_t1, 1'b0} || clock_out[0] !== 1'b0) begin
            tests_failed++;
            $display("FAIL hold_%0d: got tick=%b clk0=%b want tick=%b clk0=0",
                     k, tick, clock_out[0], {exp_t1, 1'b0});
         end
      end
      enable = 2'b11;
      @(negedge clock_in);
      tests_run++;
      if (tick !== 2'b10) begin
         tests_failed++;
         $display("FAIL resume_1: got tick=%b want 10", tick);
      end
      @(negedge clock_in);
      tests_run++;
      if (tick !== 2'b01 || clock_out[0] !== 1'b1) begin
         tests_failed++;
         $display("FAIL resume_2: got tick=%b clk0=%b want tick=01 clk0=1", tick, clock_out[0]);
      end
      $display("[TB] test_hold: channel 0 paused 5 cycles done");
   endtask

   task automatic test_bad_sel;
      logic [CH-1:0] exp_tick;
      do_reset(2'b11, 2'b00);
      @(negedge clock_in);
      @(negedge clock_in);
      load       = 1'b1;
      load_sel   = 2'd2;
      divisor_in = 24'd0;
      for (int e = 3; e <= 8; e++) begin
         @(negedge clock_in);
         load     = 1'b0;
         exp_tick = (e == 4 || e == 8) ? 2'b11 : 2'b00;
         tests_run++;
         if (tick !== exp_tick) begin
            tests_failed++;
            $display("FAIL bad_sel_edge%0d: got tick=%b want %b", e, tick, exp_tick);
         end
      end
      $display("[TB] test_bad_sel: load_sel=2 ignored done");
   endtask

   task automatic test_async_reset;
      logic [CH-1:0] exp_tick;
      do_reset(2'b11, 2'b00);
      for (int k = 1; k <= 4; k++) @(negedge clock_in);
      tests_run++;
      if (tick !== 2'b11 || clock_out !== 2'b11) begin
         tests_failed++;
         $display("FAIL pre_reset: got tick=%b clk=%b want tick=11 clk=11", tick, clock_out);
      end
      #1 reset_n = 1'b0;
      #1;
      tests_run++;
      if (tick !== 2'b00 || clock_out !== 2'b00) begin
         tests_failed++;
         $display("FAIL async_clear: got tick=%b clk=%b want tick=00 clk=00", tick, clock_out);
      end
      @(negedge clock_in);
      reset_n = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         @(negedge clock_in);
         exp_tick = (k == 4) ? 2'b11 : 2'b00;
         tests_run++;
         if (tick !== exp_tick) begin
            tests_failed++;
            $display("FAIL post_reset_edge%0d: got tick=%b want %b", k, tick, exp_tick);
         end
      end
      $display("[TB] test_async_reset: mid-count reset done");
   endtask

`ifdef CLOCK_DIV_STEP_EN
   task automatic test_step;
      logic exp_t0, exp_t1, exp_c0, exp_c1;
      do_reset(2'b11, 2'b01);
      for (int e = 1; e <= 15; e++) begin
         step = (e == 2 || e == 3 || e == 7 || e == 8 || e == 12 || e == 13);
         @(negedge clock_in);
         exp_t0 = (e == 3 || e == 8 || e == 13);
         exp_c0 = (e >= 13) ? 1'b1 : (e >= 8) ? 1'b0 : (e >= 3);
         exp_t1 = (e % 4 == 0);
         exp_c1 = ((e / 4) % 2 == 1);
         tests_run++;
         if (tick !== {exp_t1, exp_t0} || clock_out !== {exp_c1, exp_c0}) begin
            tests_failed++;
            $display("FAIL step_edge%0d: got tick=%b clk=%b want tick=%b clk=%b",
                     e, tick, clock_out, {exp_t1, exp_t0}, {exp_c1, exp_c0});
         end
      end
      step = 1'b0;
      $display("[TB] test_step: three manual steps on channel 0 done");
   endtask
`endif

   initial begin
      test_reset();
      test_load();
      test_hold();
      test_bad_sel();
      test_async_reset();
`ifdef CLOCK_DIV_STEP_EN
      test_step();
`endif
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/clock_divider_bank.md
# clock_divider_bank

Multi-channel programmable clock/tick generator, successor to the fixed 27 MHz → ~1 Hz divider. It gives N independent channels. Each channel has a divisor loadable at run time, a per-channel enable, a square-wave output and a one-cycle tick strobe. An optional single-step mode lets the CPU core be clocked by hand from a button during bring-up. It sits in the dock, between the board oscillator and the CPU/LED logic.

## Interface
- `CHANNELS`, 2 — number of independent channels (1..8)
- `COUNT_WIDTH`, 24 — width of the divisor and counter
- `DEFAULT_DIVISOR`, 13_499_999 — divisor loaded at reset; half-period = DEFAULT_DIVISOR+1 cycles
- `SEL_WIDTH`, $clog2(CHANNELS) with a minimum of 1 — width of load_sel

- `clock_in`  in  1  system clock, 27 MHz
- `reset_n`  in  1  asynchronous, active-low reset
- `enable`  in  CHANNELS  per-channel run enable
- `load`  in  1  single-cycle strobe: write divisor_in into channel load_sel
- `load_sel`  in  SEL_WIDTH  target channel for load
- `divisor_in`  in  COUNT_WIDTH  new divisor (half-period − 1)
- `step_mode`  in  CHANNELS  per-channel manual-step select (only with STEP_EN)
- `step`  in  1  manual step request, already synchronised and debounced (only with STEP_EN)
- `clock_out`  out  CHANNELS  divided square wave
- `tick`  out  CHANNELS  one-cycle pulse on each clock_out toggle

## Operation
- Per-channel state: `div[i]` (COUNT_WIDTH), `cnt[i]` (COUNT_WIDTH), `clock_out[i]`, `tick[i]`. All state is registered.
- Reset values: div = DEFAULT_DIVISOR, cnt = 0, clock_out = 0, tick = 0, step history = 0.
- Priority per channel, highest first: load, step mode, enable, hold.
- **Load**: when load=1 and load_sel=i:
  - div[i] ← divisor_in and cnt[i] ← 0.
  - clock_out[i] holds and tick[i] = 0 that cycle.
  - If load_sel ≥ CHANNELS, the load is ignored.
- **Run**: when enable[i]=1 (not loading, not in step mode):
  - If cnt == div: cnt ← 0, clock_out toggles, tick ← 1.
  - Otherwise: cnt ← cnt+1, tick ← 0.
  - Period = 2·(div+1) cycles. div = 0 gives clock_in/2 with tick high every cycle.
- **Hold**: when enable[i]=0, cnt and clock_out hold and tick = 0. Re-enabling resumes from the held cnt (phase preserved).
- **Counter bound**: cnt never exceeds div, because every divisor load clears cnt. No wrap-around case exists.
- **Step** (STEP_EN only):
  - The block detects a rising edge of step (step=1 while the previous sample was 0).
  - Every channel with step_mode[i]=1 toggles clock_out and asserts tick for one cycle on that edge, regardless of enable[i].
  - While step_mode[i]=1, cnt[i] is held at 0. Leaving step mode therefore gives a full half-period before the next automatic toggle.
  - A load in the same cycle as a step edge wins for that channel; the step edge is lost for it only.

## Timing
- Latency is zero cycles from the counter match to the output: tick and clock_out update on the same edge and are both registered.
- After reset release with enable=1: the first toggle happens on the (div+1)-th clock_in edge, and then every div+1 edges after that.
- After a load, the next toggle happens on the (divisor_in+1)-th edge after the load edge.
- A step rising edge produces its toggle on the edge after the one that samples step=1. This is 1-cycle latency.
- If reset_n is asserted mid-count, outputs clear immediately (asynchronously). Counting restarts from reset values on the first edge after release.

## Configuration
- `CLOCK_DIV_STEP_EN`
  - Defined: the step_mode and step ports exist, along with the edge-detect register and the step-mode path.
  - Undefined: those ports and logic are removed, and the block behaves as if step_mode = 0.

## Structure
- Package `clock_div_pkg` holds:
  - the COUNT_WIDTH default;
  - the DEFAULT_DIVISOR constant (13_499_999);
  - the constant FAST_DIVISOR = 0, used for simulation and test.
- Sub-module `clock_div_channel` is one channel's div/cnt/toggle logic. The top instantiates it CHANNELS times with a generate loop and decodes load/load_sel and the step edge into per-channel strobes.

## Test plan
- Reset, DEFAULT_DIVISOR overridden to 3, enable=11 → both clock_out toggle every 4 cycles (period 8); tick pulses on cycles 4, 8, 12.
- Load div=1 into channel 1 mid-period → channel 1 cnt restarts, toggles 2 edges after the load, then every 2. Channel 0 is unaffected.
- enable[0]=0 for 5 cycles at cnt=2 → no tick, clock_out frozen. Re-enable → toggle after 2 more edges (div=3).
- Load with load_sel=2 when CHANNELS=2 → no divisor or phase change on any channel.
- STEP_EN, step_mode=01, three step pulses → channel 0 toggles 3 times with 3 single-cycle ticks; channel 1 keeps its free-running rhythm.
- Assert reset_n low mid-count between edges → clock_out and tick go to 0 immediately. After release, the first toggle arrives at div+1 edges.
